// File: rtl/i2c_target_regs.sv
// I2C target with a local register bank: oversampled SCL/SDA, 7-bit address match,
// pointer-then-data writes, auto-incrementing reads, open-drain SDA drive.
module i2c_target_regs #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 7,
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'b1010101,
  parameter int                REG_DEPTH   = 16,
  parameter int                SYNC_STAGES = 2,
  localparam int               PW          = $clog2(REG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [PW-1:0]     host_addr,
  input  logic              host_we,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              wr_strobe,
  output logic [PW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  scl_sync_q, sda_sync_q;
  logic                    scl_prev_q, sda_prev_q;
  logic [2:0]              cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic                    rw_q, rw_d;
  logic [DATA_W-2:0]       sr_q, sr_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic                    sda_oe_q, sda_oe_d;
  logic                    busy_q, busy_d;
  logic                    wr_strobe_q;
  logic [PW-1:0]           wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic [DATA_W-1:0]       host_rdata_q;
  logic [DATA_W-1:0]       regs_q [REG_DEPTH];
  logic                    bus_we;

  logic scl_cur, sda_cur, scl_rise, scl_fall, start_det, stop_det;
  logic [DATA_W-1:0] byte_in, rd_byte;

  assign scl_cur   = scl_sync_q[SYNC_STAGES-1];
  assign sda_cur   = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = ~scl_prev_q & scl_cur;
  assign scl_fall  = scl_prev_q & ~scl_cur;
  // SCL must be high in both samples, so an SDA change coincident with an SCL edge is data
  assign start_det = scl_prev_q & scl_cur & sda_prev_q & ~sda_cur;
  assign stop_det  = scl_prev_q & scl_cur & ~sda_prev_q & sda_cur;
  assign byte_in   = {sr_q, sda_cur};
  assign rd_byte   = regs_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    rw_d      = rw_q;
    sr_d      = sr_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    bus_we    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR_BYTE: if (scl_rise) begin
          sr_d  = byte_in[DATA_W-2:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            phase_d = 1'b0;
            if (state_q == ADDR) begin
              rw_d = byte_in[0];
              if (byte_in[ADDR_W:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == PTR) begin
              ptr_d   = byte_in[PW-1:0];
              state_d = WR_ACK;
            end else begin
              bus_we    = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_in;
              ptr_d     = ptr_q + PW'(1);
              state_d   = WR_ACK;
            end
          end
        end
        // phase 0: fall that starts the ACK slot; phase 1: fall that ends it
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            cnt_d   = '0;
            if (state_q == ADDR_ACK && rw_q) begin
              sr_d     = rd_byte[DATA_W-2:0];
              sda_oe_d = ~rd_byte[DATA_W-1];
              state_d  = RD_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = (state_q == ADDR_ACK) ? PTR : WR_BYTE;
            end
          end
        end
        RD_BYTE: if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            phase_d  = 1'b0;
            state_d  = RD_ACK;
          end else begin
            sda_oe_d = ~sr_q[DATA_W-2];
            sr_d     = {sr_q[DATA_W-3:0], 1'b0};
            cnt_d    = cnt_q + 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise && !phase_q) begin
            if (!sda_cur) begin
              ptr_d   = ptr_q + PW'(1);
              phase_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else if (scl_fall && phase_q) begin
            sr_d     = rd_byte[DATA_W-2:0];
            sda_oe_d = ~rd_byte[DATA_W-1];
            cnt_d    = '0;
            phase_d  = 1'b0;
            state_d  = RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      rw_q         <= 1'b0;
      sr_q         <= '0;
      ptr_q        <= '0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      host_rdata_q <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
    end else begin
      scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q   <= scl_cur;
      sda_prev_q   <= sda_cur;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      rw_q         <= rw_d;
      sr_q         <= sr_d;
      ptr_q        <= ptr_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      wr_strobe_q  <= bus_we;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      host_rdata_q <= regs_q[host_addr];
      // bus write is applied last so it wins a same-cycle collision with the host
      if (host_we) regs_q[host_addr] <= host_wdata;
      if (bus_we)  regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged controller drives the bus,
// every observation is checked with an immediate assertion against hand-computed values.
module tb_i2c_target_regs;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic [3:0] host_addr = '0;
  logic       host_we = 1'b0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int vectors = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  assign sda_in = sda_m & ~sda_oe;

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda_in(sda_in), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    if (sda_oe)    oe_cnt     <= oe_cnt + 1;
    if (busy)      busy_cnt   <= busy_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_cyc(H); scl_m = 1'b1; wait_cyc(H);
    sda_m = 1'b0; wait_cyc(H); scl_m = 1'b0;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_cyc(H); scl_m = 1'b1; wait_cyc(H);
    sda_m = 1'b1; wait_cyc(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit col, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_cyc(H); scl_m = 1'b1;
      if (col && i == 0) begin
        wait_cyc(2);
        host_addr = 4'd5; host_wdata = 8'h01; host_we = 1'b1;
        wait_cyc(1);
        host_we = 1'b0;
        check("col_strobe", 32'(wr_strobe), 32'd1);
        wait_cyc(H - 3);
      end else begin
        wait_cyc(H);
      end
      scl_m = 1'b0;
    end
    sda_m = 1'b1; wait_cyc(H); scl_m = 1'b1; wait_cyc(H / 2);
    ack = sda_in; wait_cyc(H / 2); scl_m = 1'b0;
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_cyc(H); scl_m = 1'b1; wait_cyc(H / 2);
      b[i] = sda_in; wait_cyc(H / 2); scl_m = 1'b0;
    end
    sda_m = ack_bit; wait_cyc(H); scl_m = 1'b1; wait_cyc(H); scl_m = 1'b0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1; wait_cyc(1); host_we = 1'b0;
  endtask

  task automatic host_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    host_addr = a; wait_cyc(2);
    check(tag, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         s0, o0, b0;

    wait_cyc(4);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    rst = 1'b1;
    wait_cyc(4);

    // write 0x5A to register 3
    s0 = strobe_cnt;
    i2c_start;
    send_byte(8'hAA, 1'b0, ack); check("w1_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h03, 1'b0, ack); check("w1_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'h5A, 1'b0, ack); check("w1_data_ack", 32'(ack), 32'd0);
    check("w1_busy", 32'(busy), 32'd1);
    i2c_stop;
    check("w1_busy_after_stop", 32'(busy), 32'd0);
    check("w1_strobes", 32'(strobe_cnt - s0), 32'd1);
    check("w1_wr_addr", 32'(wr_addr), 32'd3);
    check("w1_wr_data", 32'(wr_data), 32'h5A);
    host_check("w1_host_reg3", 4'd3, 8'h5A);

    // pointer write, repeated START, single-byte read with NACK
    i2c_start;
    send_byte(8'hAA, 1'b0, ack); check("r1_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h03, 1'b0, ack); check("r1_ptr_ack", 32'(ack), 32'd0);
    i2c_start;
    send_byte(8'hAB, 1'b0, ack); check("r1_raddr_ack", 32'(ack), 32'd0);
    recv_byte(1'b1, rb); check("r1_data", 32'(rb), 32'h5A);
    i2c_stop;
    check("r1_sda_oe_after_stop", 32'(sda_oe), 32'd0);
    check("r1_busy_after_stop", 32'(busy), 32'd0);

    // wrong address 0x2A is ignored
    s0 = strobe_cnt; o0 = oe_cnt; b0 = busy_cnt;
    i2c_start;
    send_byte(8'h54, 1'b0, ack); check("na_addr_nack", 32'(ack), 32'd1);
    send_byte(8'h00, 1'b0, ack); check("na_data_nack", 32'(ack), 32'd1);
    i2c_stop;
    check("na_no_oe", 32'(oe_cnt - o0), 32'd0);
    check("na_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("na_no_busy", 32'(busy_cnt - b0), 32'd0);
    host_check("na_reg3_kept", 4'd3, 8'h5A);
    host_check("na_reg0_kept", 4'd0, 8'h00);

    // two-byte read wrapping from register 15 to register 0
    host_write(4'd15, 8'hA5);
    host_write(4'd0, 8'h11);
    i2c_start;
    send_byte(8'hAA, 1'b0, ack); check("wr_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h0F, 1'b0, ack); check("wr_ptr_ack", 32'(ack), 32'd0);
    i2c_start;
    send_byte(8'hAB, 1'b0, ack); check("wr_raddr_ack", 32'(ack), 32'd0);
    recv_byte(1'b0, rb); check("wrap_byte0", 32'(rb), 32'hA5);
    recv_byte(1'b1, rb); check("wrap_byte1", 32'(rb), 32'h11);
    i2c_stop;

    // reset pulse in the middle of a read (ptr is 0, reg0 holds 0x00 so SDA is pulled)
    host_write(4'd0, 8'h00);
    i2c_start;
    send_byte(8'hAB, 1'b0, ack); check("rr_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      sda_m = 1'b1; wait_cyc(H); scl_m = 1'b1; wait_cyc(H); scl_m = 1'b0;
    end
    wait_cyc(6);
    check("rr_oe_before_rst", 32'(sda_oe), 32'd1);
    rst = 1'b0; wait_cyc(1); rst = 1'b1;
    check("rr_oe_after_rst", 32'(sda_oe), 32'd0);
    check("rr_busy_after_rst", 32'(busy), 32'd0);
    wait_cyc(H);
    i2c_stop;
    host_check("rr_reg15_cleared", 4'd15, 8'h00);
    s0 = strobe_cnt;
    i2c_start;
    send_byte(8'hAA, 1'b0, ack); check("rr_w_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h02, 1'b0, ack); check("rr_w_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'h77, 1'b0, ack); check("rr_w_data_ack", 32'(ack), 32'd0);
    i2c_stop;
    check("rr_w_strobes", 32'(strobe_cnt - s0), 32'd1);
    host_check("rr_reg2", 4'd2, 8'h77);

    // bus and host write register 5 on the same edge
    i2c_start;
    send_byte(8'hAA, 1'b0, ack); check("col_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h05, 1'b0, ack); check("col_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'h99, 1'b1, ack); check("col_data_ack", 32'(ack), 32'd0);
    i2c_stop;
    check("col_wr_addr", 32'(wr_addr), 32'd5);
    check("col_wr_data", 32'(wr_data), 32'h99);
    host_check("col_reg5", 4'd5, 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
